// File: rtl/counter_pkg.sv
// Shared constants for the display refresh slice: 7-segment patterns in
// {dp,g,f,e,d,c,b,a} order (active high, dp unused), frame FSM states and
// the number of serial bits each digit occupies in the driver chain.
package counter_pkg;

  localparam int unsigned BITS_PER_DIGIT = 8;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_DASH = 8'h40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/display_refresh_if.sv
// Bus between the counter/trigger side and the display refresher.
//   ref_clk   : one-cycle refresh request
//   digits    : BCD count value, digit i at [4i+3:4i]
//   ser_data  : serial segment data to the 595 chain
//   ser_clk   : shift clock (drivers sample on rising edge)
//   ser_latch : storage latch pulse
//   busy      : frame in flight
// master = producer of requests / consumer of serial outputs; slave = refresher.
interface display_refresh_if #(
  parameter int DIGITS = 6
);
  logic                  ref_clk;
  logic [4*DIGITS-1:0]   digits;
  logic                  ser_data;
  logic                  ser_clk;
  logic                  ser_latch;
  logic                  busy;

  modport master (
    output ref_clk, digits,
    input  ser_data, ser_clk, ser_latch, busy
  );

  modport slave (
    input  ref_clk, digits,
    output ser_data, ser_clk, ser_latch, busy
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder.
//   bcd : 4-bit BCD digit
//   seg : pattern {dp,g,f,e,d,c,b,a}; codes 10..15 show a dash
module bcd_to_7seg
  import counter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_refresh.sv
// Snapshots the BCD counter on each refresh request and shifts the decoded
// frame into a chain of 595-style drivers, most significant digit first,
// dp bit first within each digit, followed by a storage latch pulse.
// Requests arriving while a frame is in flight coalesce into one follow-up.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : display_refresh_if slave (ref_clk/digits in,
//                  ser_data/ser_clk/ser_latch/busy out, all registered)
module display_refresh
  import counter_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int HALF_PERIOD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  display_refresh_if.slave  bus
);

  localparam int unsigned NBITS = BITS_PER_DIGIT * DIGITS;
  localparam int unsigned BW    = $clog2(NBITS);
  localparam int unsigned PW    = $clog2(HALF_PERIOD + 1);
  localparam int unsigned DSH   = $clog2(BITS_PER_DIGIT);

  state_t              state;
  logic                pending;
  logic [4*DIGITS-1:0] snap;
  logic [BW-1:0]       bit_cnt;
  logic [PW-1:0]       phase;
  logic                half;      // 0: ser_clk low half of bit, 1: high half

  logic [BW-1:0]       digit_idx;
  logic [3:0]          cur_bcd;
  logic [7:0]          cur_seg;
  logic                cur_bit;
  logic                phase_last;
  logic                bit_last;

  assign phase_last = (phase == PW'(HALF_PERIOD - 1));
  assign bit_last   = (bit_cnt == BW'(NBITS - 1));

  // Bit counter runs 0..NBITS-1 in transmit order, so the upper bits count
  // digits down from the most significant one and the low bits walk dp..a.
  always_comb begin
    digit_idx = BW'(DIGITS - 1) - (bit_cnt >> DSH);
    cur_bcd   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_idx == BW'(i)) cur_bcd = snap[4*i +: 4];
    end
  end

  bcd_to_7seg u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  assign cur_bit = cur_seg[~bit_cnt[2:0]];

  // Outputs are registered views of the current state, so they trail the
  // FSM by one cycle; this gives the first bit one edge after the request
  // is taken and keeps data/clock phase-aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      snap          <= '0;
      bit_cnt       <= '0;
      phase         <= '0;
      half          <= 1'b0;
      bus.ser_data  <= 1'b0;
      bus.ser_clk   <= 1'b0;
      bus.ser_latch <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.ser_data  <= (state == SHIFT) && cur_bit;
      bus.ser_clk   <= (state == SHIFT) && half;
      bus.ser_latch <= (state == LATCH);
      bus.busy      <= (state != IDLE);

      case (state)
        IDLE: begin
          if (bus.ref_clk) begin
            snap    <= bus.digits;
            bit_cnt <= '0;
            phase   <= '0;
            half    <= 1'b0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (bus.ref_clk) pending <= 1'b1;
          if (phase_last) begin
            phase <= '0;
            if (!half) begin
              half <= 1'b1;
            end else begin
              half <= 1'b0;
              if (bit_last) state   <= LATCH;
              else          bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        LATCH: begin
          if (phase_last) begin
            phase <= '0;
            // A request in this final cycle restarts directly, same as pending.
            if (pending || bus.ref_clk) begin
              snap    <= bus.digits;
              bit_cnt <= '0;
              half    <= 1'b0;
              pending <= 1'b0;
              state   <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end else begin
            phase <= phase + 1'b1;
            if (bus.ref_clk) pending <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
